// File: rtl/piso_serial_tx.sv
// piso_serial_tx: valid/ready parallel-in, serial-out transmitter with registered outputs.
// Define PISO_PARITY_EN to append an even-parity bit and expose sout_parity.
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
`ifdef PISO_PARITY_EN
  ,
  output logic             sout_parity
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic par, par_n, sout_n, valid_n, start_n, ready_n, accept, last;
  assign accept = din_valid & din_ready;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = sout_valid;
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    par_n   = par;
    sout_n  = 1'b0;
    valid_n = 1'b0;
    start_n = 1'b0;
    ready_n = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      sr_n    = din;
      cnt_n   = '0;
      par_n   = ^din;
      sout_n  = MSB_FIRST ? din[WIDTH-1] : din[0];
      valid_n = 1'b1;
      start_n = 1'b1;
    end else if (state == SHIFT && !last) begin
      sr_n    = MSB_FIRST ? sr << 1 : sr >> 1;
      cnt_n   = cnt + 1'b1;
      sout_n  = MSB_FIRST ? sr[WIDTH-2] : sr[1];
      valid_n = 1'b1;
      ready_n = !PAR && cnt == CW'(WIDTH - 2);
    end else if (state == SHIFT && PAR) begin
      state_n = PARITY;
      cnt_n   = '0;
      sout_n  = par;
      valid_n = 1'b1;
      ready_n = 1'b1;
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
      ready_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      par         <= 1'b0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      din_ready   <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      cnt         <= cnt_n;
      par         <= par_n;
      sout        <= sout_n;
      sout_valid  <= valid_n;
      frame_start <= start_n;
      din_ready   <= ready_n;
    end
  end
`ifdef PISO_PARITY_EN
  always_ff @(posedge clk) sout_parity <= reset && state_n == PARITY;
`endif
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: MSB-first and LSB-first instances checked every cycle against a
// queue model of the expected serial beats; directed spec cases followed by random traffic.
module tb_piso_serial_tx;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b0, din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic rdy_m, sout_m, sv_m, fs_m, busy_m, sp_m;
  logic rdy_l, sout_l, sv_l, fs_l, busy_l, sp_l;
  typedef struct packed {logic b; logic fs; logic p;} beat_t;
  beat_t qm[$], ql[$];
  logic erdy = 1'b0, acc = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .sout(sout_m), .sout_valid(sv_m), .frame_start(fs_m), .busy(busy_m)
`ifdef PISO_PARITY_EN
    , .sout_parity(sp_m)
`endif
  );
  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .sout(sout_l), .sout_valid(sv_l), .frame_start(fs_l), .busy(busy_l)
`ifdef PISO_PARITY_EN
    , .sout_parity(sp_l)
`endif
  );
`ifndef PISO_PARITY_EN
  assign sp_m = 1'b0;
  assign sp_l = 1'b0;
`endif

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic lane(input string n, input beat_t q[$], input logic rdy, input logic so,
                      input logic sv, input logic fs, input logic bz, input logic sp);
    beat_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    chk({n, ".din_ready"}, rdy, erdy);
    chk({n, ".sout_valid"}, sv, q.size() > 0);
    chk({n, ".busy"}, bz, q.size() > 0);
    chk({n, ".sout"}, so, e.b);
    chk({n, ".frame_start"}, fs, e.fs);
`ifdef PISO_PARITY_EN
    chk({n, ".sout_parity"}, sp, e.p);
`endif
  endtask

  // Model: each queue holds the beats still to appear on sout, head = current cycle.
  task automatic step();
    @(posedge clk);
    acc = 1'b0;
    if (!reset) begin
      qm.delete();
      ql.delete();
      erdy = 1'b0;
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (din_valid && erdy) begin
        acc = 1'b1;
        for (int k = 0; k < W; k++) begin
          qm.push_back('{din[W-1-k], k == 0, 1'b0});
          ql.push_back('{din[k], k == 0, 1'b0});
        end
`ifdef PISO_PARITY_EN
        qm.push_back('{^din, 1'b0, 1'b1});
        ql.push_back('{^din, 1'b0, 1'b1});
`endif
      end
      erdy = qm.size() <= 1;
    end
    #1;
    lane("msb", qm, rdy_m, sout_m, sv_m, fs_m, busy_m, sp_m);
    lane("lsb", ql, rdy_l, sout_l, sv_l, fs_l, busy_l, sp_l);
  endtask

  task automatic send(input logic [W-1:0] w);
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc) break;
    end
    chk("accept_within_bound", acc, 1'b1);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din = W'($urandom);
      step();
    end
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b1;
    step();
    send(8'hA5);
    idle(10);
    send(8'h01);
    idle(10);
    send(8'hA5);
    send(8'h3C);
    idle(11);
    send(8'hA5);
    send(8'hFF);
    idle(11);
    send(8'h07);
    idle(11);
    send(8'hA5);
    idle(2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle(12);
    for (int i = 0; i < 500; i++) begin
      reset = $urandom_range(0, 39) != 0;
      din_valid = $urandom_range(0, 2) != 0;
      din = W'($urandom);
      step();
    end
    reset = 1'b1;
    din_valid = 1'b0;
    idle(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
